// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing defaults and the pixel coordinate type.
// videoGenerador imports this package too, so the coordinate width stays in one place.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COORD_W      = 10;
  localparam int COORD_LIMIT  = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: driven by vga_timing_gen, consumed by videoGenerador and the DAC pins.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_en;
  logic   vga_clk;
  coord_t cuentaX;
  coord_t cuentaY;
  logic   hsync;
  logic   vsync;
  logic   blank_n;
  logic   sync_n;
  logic   frame_tick;

  modport master (
    output pix_en, vga_clk, cuentaX, cuentaY, hsync, vsync, blank_n, sync_n, frame_tick
  );

  modport slave (
    input pix_en, vga_clk, cuentaX, cuentaY, hsync, vsync, blank_n, sync_n, frame_tick
  );

endinterface

// File: rtl/vga_timing_gen_clk_en_div.sv
// Pixel-rate divider: one-clk pix_en strobe per pixel plus a registered square-wave
// pixel clock for the DAC. Both outputs come straight from flops.
module clk_en_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_pix_en,
  output logic o_vga_clk
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pix_en;
  logic          r_vga_clk;

  // Wrap-around divide count; pix_en is the registered terminal-count decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_cnt    <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      r_pix_en <= (r_cnt == LAST);
    end
  end

  // With no division the DAC should run from clk itself, so vga_clk just parks high.
  if (DIV == 1) begin : g_div1
    // Constant-high pixel clock after reset.
    always_ff @(posedge clk) begin
      if (rst) r_vga_clk <= 1'b0;
      else     r_vga_clk <= 1'b1;
    end
  end else begin : g_divn
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);
    // Second half of the divide period drives vga_clk high, putting its rise mid-pixel.
    always_ff @(posedge clk) begin
      if (rst) r_vga_clk <= 1'b0;
      else     r_vga_clk <= (r_cnt >= HALF);
    end
  end

  assign o_pix_en  = r_pix_en;
  assign o_vga_clk = r_vga_clk;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel/line counters, sync and blank decodes, DAC controls
// and a once-per-frame tick at the start of vertical blanking.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  o_vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  // Sync/blank bounds are 11 bits wide so an end bound of exactly 1024 still compares correctly.
  localparam coord_t      X_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t      Y_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t      Y_ACT    = coord_t'(V_ACTIVE);
  localparam logic [10:0] X_ACT11  = 11'(H_ACTIVE);
  localparam logic [10:0] Y_ACT11  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic   w_pix_en;
  logic   w_vga_clk;
  logic   w_x_wrap;
  coord_t w_x_nxt;
  coord_t w_y_nxt;

  coord_t r_x;
  coord_t r_y;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_blank_n;
  logic   r_frame_tick;

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .rst       (rst),
    .o_pix_en  (w_pix_en),
    .o_vga_clk (w_vga_clk)
  );

  // Next raster position; holds between pixel strobes.
  always_comb begin
    w_x_wrap = w_pix_en && (r_x == X_LAST);
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    if (w_pix_en) begin
      w_x_nxt = w_x_wrap ? '0 : r_x + coord_t'(1);
      if (w_x_wrap) w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + coord_t'(1);
    end
  end

  // Counters plus decodes of their next values, so every output moves on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_blank_n    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_hsync      <= !(({1'b0, w_x_nxt} >= HS_START) && ({1'b0, w_x_nxt} < HS_END));
      r_vsync      <= !(({1'b0, w_y_nxt} >= VS_START) && ({1'b0, w_y_nxt} < VS_END));
      r_blank_n    <= ({1'b0, w_x_nxt} < X_ACT11) && ({1'b0, w_y_nxt} < Y_ACT11);
      r_frame_tick <= w_x_wrap && (w_y_nxt == Y_ACT);
    end
  end

  assign o_vga.pix_en     = w_pix_en;
  assign o_vga.vga_clk    = w_vga_clk;
  assign o_vga.cuentaX    = r_x;
  assign o_vga.cuentaY    = r_y;
  assign o_vga.hsync      = r_hsync;
  assign o_vga.vsync      = r_vsync;
  assign o_vga.blank_n    = r_blank_n;
  assign o_vga.sync_n     = 1'b0;
  assign o_vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing build, a shrunken-raster build (CLK_DIV=2)
// and a shrunken CLK_DIV=1 build, each compared every cycle against an arithmetic model
// of clocks elapsed since reset, plus a hand-derived vector table and frame-tick checks.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HA = 16, S_HFP = 2, S_HS = 3, S_HBP = 3;
  localparam int S_VA = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;

  typedef struct packed {
    logic       pix_en;
    logic       vga_clk;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       sn;
    logic       ft;
  } obs_t;

  typedef struct {
    int div; int ha; int hfp; int hs; int hbp; int va; int vfp; int vs; int vbp;
  } cfg_t;

  typedef struct {
    int t; int x; int y; logic hs; logic bn; logic pe;
  } vec_t;

  cfg_t cfg_def = '{DEF_CLK_DIV, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                    DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP};
  cfg_t cfg_sml = '{2, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};
  cfg_t cfg_one = '{1, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def = 1'b1, rst_sml = 1'b1, rst_one = 1'b1;
  logic chk_on = 1'b0;
  logic line0_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int t_def = 0, t_sml = 0, t_one = 0;
  int cyc = 0;
  int hs_low_def = 0, bn_low_def = 0;
  int ticks_sml[$];
  int ticks_one[$];
  vec_t vecs[$];

  vga_timing_gen_if if_def();
  vga_timing_gen_if if_sml();
  vga_timing_gen_if if_one();

  vga_timing_gen u_def (.clk(clk), .rst(rst_def), .o_vga(if_def));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_sml (.clk(clk), .rst(rst_sml), .o_vga(if_sml));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) u_one (.clk(clk), .rst(rst_one), .o_vga(if_one));

  // Pixels consumed after t clk edges since the reset edge: strobes appear after edges
  // div, 2*div, ... and each is consumed by the following edge.
  function automatic int pixels(input int t, input int div);
    return (t <= 0) ? 0 : (t - 1) / div;
  endfunction

  function automatic obs_t model(input cfg_t c, input int t);
    obs_t m;
    int ht, vt, p, x, y;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    p  = pixels(t, c.div);
    x  = p % ht;
    y  = (p / ht) % vt;
    m.pix_en  = (t >= 1) && (t % c.div == 0);
    m.vga_clk = (t >= 1) && (((t - 1) % c.div) >= c.div / 2);
    m.x       = 10'(x);
    m.y       = 10'(y);
    m.hs      = !(x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs);
    m.vs      = !(y >= c.va + c.vfp && y < c.va + c.vfp + c.vs);
    m.bn      = (x < c.ha) && (y < c.va);
    m.sn      = 1'b0;
    m.ft      = (t >= 2) && (p != pixels(t - 1, c.div)) && ((p % (ht * vt)) == c.va * ht);
    return m;
  endfunction

  task automatic check_obs(input string nm, input obs_t a, input obs_t e, input int t);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0d got {pe,vclk,x,y,hs,vs,bn,sn,ft}=%b,%b,%0d,%0d,%b,%b,%b,%b,%b expected %b,%b,%0d,%0d,%b,%b,%b,%b,%b",
               nm, t, a.pix_en, a.vga_clk, a.x, a.y, a.hs, a.vs, a.bn, a.sn, a.ft,
               e.pix_en, e.vga_clk, e.x, e.y, e.hs, e.vs, e.bn, e.sn, e.ft);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, a, e);
    end
  endtask

  // Elapsed-clock trackers: a clk edge with rst high restarts the count.
  always @(posedge clk) begin
    t_def <= rst_def ? 0 : t_def + 1;
    t_sml <= rst_sml ? 0 : t_sml + 1;
    t_one <= rst_one ? 0 : t_one + 1;
    cyc   <= cyc + 1;
  end

  // Per-cycle scoreboard against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check_obs("cyc_def", {if_def.pix_en, if_def.vga_clk, if_def.cuentaX, if_def.cuentaY,
                 if_def.hsync, if_def.vsync, if_def.blank_n, if_def.sync_n, if_def.frame_tick},
                model(cfg_def, t_def), t_def);
      check_obs("cyc_sml", {if_sml.pix_en, if_sml.vga_clk, if_sml.cuentaX, if_sml.cuentaY,
                 if_sml.hsync, if_sml.vsync, if_sml.blank_n, if_sml.sync_n, if_sml.frame_tick},
                model(cfg_sml, t_sml), t_sml);
      check_obs("cyc_one", {if_one.pix_en, if_one.vga_clk, if_one.cuentaX, if_one.cuentaY,
                 if_one.hsync, if_one.vsync, if_one.blank_n, if_one.sync_n, if_one.frame_tick},
                model(cfg_one, t_one), t_one);
      if (if_sml.frame_tick) ticks_sml.push_back(cyc);
      if (if_one.frame_tick) ticks_one.push_back(cyc);
      if (!line0_done && t_def >= 1 && t_def <= 1600 && if_def.pix_en) begin
        if (!if_def.hsync)   hs_low_def++;
        if (!if_def.blank_n) bn_low_def++;
      end
    end
  end

  task automatic def_seq();
    int g;
    @(negedge clk);
    foreach (vecs[i]) begin
      g = 0;
      while (t_def < vecs[i].t && g < 5000) begin
        @(negedge clk);
        g++;
      end
      n_checks++;
      if (t_def != vecs[i].t || int'(if_def.cuentaX) != vecs[i].x || int'(if_def.cuentaY) != vecs[i].y ||
          if_def.hsync !== vecs[i].hs || if_def.blank_n !== vecs[i].bn || if_def.pix_en !== vecs[i].pe) begin
        n_fail++;
        $display("FAIL vec%0d t=%0d got x=%0d y=%0d hs=%b bn=%b pe=%b expected t=%0d x=%0d y=%0d hs=%b bn=%b pe=%b",
                 i, t_def, if_def.cuentaX, if_def.cuentaY, if_def.hsync, if_def.blank_n, if_def.pix_en,
                 vecs[i].t, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].bn, vecs[i].pe);
      end
    end
    line0_done = 1'b1;
    check_int("hsync_low_pixels_line0", hs_low_def, 96);
    check_int("blank_low_pixels_line0", bn_low_def, 160);

    // Reset mid-line at (700,1): the very next edge must land on (0,0).
    g = 0;
    while (t_def < 3001 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check_int("pre_rst_x", int'(if_def.cuentaX), 700);
    check_int("pre_rst_y", int'(if_def.cuentaY), 1);
    rst_def = 1'b1;
    @(negedge clk);
    check_int("mid_rst_xy", int'({if_def.cuentaX, if_def.cuentaY}), 0);
    check_int("mid_rst_hs_bn_vs", int'({if_def.hsync, if_def.blank_n, if_def.vsync}), 7);
    check_int("mid_rst_pe_ft", int'({if_def.pix_en, if_def.frame_tick}), 0);
    @(posedge clk);
    #1 rst_def = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic frame_seq(input bit one, input int window, input int spacing);
    int q[$];
    if (one) ticks_one.delete(); else ticks_sml.delete();
    repeat (window) @(negedge clk);
    #1;
    q = one ? ticks_one : ticks_sml;
    check_int(one ? "ticks_one_count" : "ticks_sml_count", q.size(), 3);
    if (q.size() >= 3) begin
      check_int(one ? "tick_gap0_one" : "tick_gap0_sml", q[1] - q[0], spacing);
      check_int(one ? "tick_gap1_one" : "tick_gap1_sml", q[2] - q[1], spacing);
    end
    // Random mid-frame reset pulses; the scoreboard follows each restart.
    repeat (6) begin
      repeat ($urandom_range(700, 40)) @(negedge clk);
      if (one) rst_one = 1'b1; else rst_sml = 1'b1;
      repeat ($urandom_range(3, 1)) @(negedge clk);
      if (one) rst_one = 1'b0; else rst_sml = 1'b0;
    end
    repeat (800) @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{0,    0,   0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1,    0,   0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2,    0,   0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{3,    1,   0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1280, 639, 0, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{1281, 640, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1312, 655, 0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1313, 656, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1503, 751, 0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1505, 752, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1599, 799, 0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1601, 0,   1, 1'b1, 1'b1, 1'b0});

    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_def = 1'b0;
    rst_sml = 1'b0;
    rst_one = 1'b0;
    fork
      def_seq();
      frame_seq(1'b0, 2200, 720);
      frame_seq(1'b1, 1200, 360);
    join
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
